// File: rtl/camera_if.sv
// Camera receiver bus: serial lane inputs plus the decoded packet outputs.
interface camera_if #(
   parameter int NUM_LANES = 2
);
   logic [NUM_LANES-1:0] data_p;
   logic [1:0]           virtual_channel;
   logic [15:0]          word_count;
   logic [7:0]           image_data [3:0];
   logic [5:0]           image_data_type;
   logic                 image_data_enable;
   logic                 interrupt;

   modport slave (
      input  data_p,
      output virtual_channel, word_count, image_data, image_data_type,
             image_data_enable, interrupt
   );

   modport master (
      output data_p,
      input  virtual_channel, word_count, image_data, image_data_type,
             image_data_enable, interrupt
   );
endinterface

// File: rtl/camera.sv
// CSI-2 style receiver: per-lane DDR deserialisation with sync hunting, round-robin lane merge, packet decode.
module camera #(
   parameter int NUM_LANES = 2
) (
   input logic     clock_p,
   input logic     reset,
   camera_if.slave cam_io
);
   localparam logic [7:0] SYNC = 8'hB8;
   typedef enum logic [2:0] {HUNT, HEADER, PAYLOAD, CRC, END} state_e;

   state_e               state_q;
   logic [NUM_LANES-1:0] nb_q, lock_q, lock_d, ph_q, ph_d, emit, hfull_q;
   logic [7:0]           sr_q   [NUM_LANES];
   logic [7:0]           mid    [NUM_LANES];
   logic [7:0]           full   [NUM_LANES];
   logic [7:0]           hold_q [NUM_LANES];
   logic [1:0]           cnt_q  [NUM_LANES];
   logic [1:0]           cnt_d  [NUM_LANES];
   logic [7:0]           grp_q  [3:0];
   logic [7:0]           wbuf_q [3:0];
   logic [7:0]           img_q  [3:0];
   logic [2:0]           rem_q;
   logic [1:0]           sel_q, hidx_q, vc_q;
   logic [7:0]           cur_byte, did_q, wcl_q, wch_q, header_ecc;
   logic [15:0]          wc_q, bcnt_q;
   logic [5:0]           dt_q;
   logic                 int_q, en_q, release_q, all_locked, take, consume;

   // The falling-edge bit is the earlier of the two bits in each clock period.
   always_ff @(negedge clock_p or posedge reset) begin
      if (reset) nb_q <= '0;
      else       nb_q <= cam_io.data_p;
   end

   // mid: alignment after the falling-edge bit; full: after both bits of the period.
   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         mid[i]    = {nb_q[i], sr_q[i][7:1]};
         full[i]   = {cam_io.data_p[i], nb_q[i], sr_q[i][7:2]};
         lock_d[i] = lock_q[i];
         ph_d[i]   = ph_q[i];
         cnt_d[i]  = cnt_q[i] + 2'd1;
         emit[i]   = 1'b0;
         if (release_q) begin
            lock_d[i] = 1'b0;
         end else if (!lock_q[i]) begin
            cnt_d[i] = 2'd0;
            if (mid[i] == SYNC) begin
               lock_d[i] = 1'b1;
               ph_d[i]   = 1'b1;
            end else if (full[i] == SYNC) begin
               lock_d[i] = 1'b1;
               ph_d[i]   = 1'b0;
            end
         end else begin
            emit[i] = (cnt_q[i] == 2'd3);
         end
      end
   end

   assign all_locked = &lock_q;
   assign cur_byte   = grp_q[sel_q];
   assign consume    = (rem_q != 3'd0) &&
                       ((state_q == HEADER) || (state_q == CRC) ||
                        ((state_q == PAYLOAD) && (bcnt_q != wc_q)));
   assign take       = (&hfull_q) && ((rem_q == 3'd0) || ((rem_q == 3'd1) && consume));

   always_ff @(posedge clock_p or posedge reset) begin
      if (reset) begin
         lock_q  <= '0;
         ph_q    <= '0;
         hfull_q <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            sr_q[i]   <= '0;
            cnt_q[i]  <= '0;
            hold_q[i] <= '0;
         end
      end else begin
         lock_q <= lock_d;
         ph_q   <= ph_d;
         for (int i = 0; i < NUM_LANES; i++) begin
            sr_q[i]  <= full[i];
            cnt_q[i] <= cnt_d[i];
            if (release_q) begin
               hfull_q[i] <= 1'b0;
            end else if (emit[i]) begin
               hold_q[i]  <= ph_q[i] ? mid[i] : full[i];
               hfull_q[i] <= 1'b1;
            end else if (take) begin
               hfull_q[i] <= 1'b0;
            end
         end
      end
   end

   // Lane merge: a full group of lane bytes is replayed one byte per cycle, lane 0 first.
   always_ff @(posedge clock_p or posedge reset) begin
      if (reset) begin
         rem_q <= '0;
         sel_q <= '0;
         for (int i = 0; i < 4; i++) grp_q[i] <= '0;
      end else if (release_q) begin
         rem_q <= '0;
      end else if (take) begin
         for (int i = 0; i < NUM_LANES; i++) grp_q[i] <= hold_q[i];
         rem_q <= 3'(NUM_LANES);
         sel_q <= '0;
      end else if (consume) begin
         rem_q <= rem_q - 3'd1;
         sel_q <= sel_q + 2'd1;
      end
   end

   always_ff @(posedge clock_p or posedge reset) begin
      if (reset) begin
         state_q    <= HUNT;
         hidx_q     <= '0;
         did_q      <= '0;
         wcl_q      <= '0;
         wch_q      <= '0;
         header_ecc <= '0;
         vc_q       <= '0;
         dt_q       <= '0;
         wc_q       <= '0;
         bcnt_q     <= '0;
         int_q      <= 1'b0;
         en_q       <= 1'b0;
         release_q  <= 1'b0;
         for (int j = 0; j < 4; j++) begin
            wbuf_q[j] <= '0;
            img_q[j]  <= '0;
         end
      end else begin
         int_q     <= 1'b0;
         en_q      <= 1'b0;
         release_q <= 1'b0;
         case (state_q)
            HUNT: begin
               // Lanes still read as locked in the cycle the release lands.
               if (all_locked && !release_q) begin
                  state_q <= HEADER;
                  hidx_q  <= '0;
               end
            end
            HEADER: begin
               if (consume) begin
                  hidx_q <= hidx_q + 2'd1;
                  case (hidx_q)
                     2'd0: did_q <= cur_byte;
                     2'd1: wcl_q <= cur_byte;
                     2'd2: wch_q <= cur_byte;
                     default: begin
                        header_ecc <= cur_byte;
                        vc_q       <= did_q[7:6];
                        dt_q       <= did_q[5:0];
                        wc_q       <= {wch_q, wcl_q};
                        bcnt_q     <= '0;
                        for (int j = 0; j < 4; j++) wbuf_q[j] <= '0;
                        if (did_q[5:0] >= 6'h10) begin
                           state_q <= PAYLOAD;
                        end else begin
                           int_q     <= 1'b1;
                           release_q <= 1'b1;
                           state_q   <= HUNT;
                        end
                     end
                  endcase
               end
            end
            PAYLOAD: begin
               if (bcnt_q == wc_q) begin
                  state_q <= CRC;
                  bcnt_q  <= '0;
               end else if (consume) begin
                  bcnt_q <= bcnt_q + 16'd1;
                  // Unused upper bytes of a short final word stay zero from the cleared buffer.
                  if ((bcnt_q[1:0] == 2'd3) || (bcnt_q + 16'd1 == wc_q)) begin
                     for (int j = 0; j < 4; j++) begin
                        img_q[j]  <= (2'(j) == bcnt_q[1:0]) ? cur_byte : wbuf_q[j];
                        wbuf_q[j] <= '0;
                     end
                     en_q  <= 1'b1;
                     int_q <= 1'b1;
                  end else begin
                     wbuf_q[bcnt_q[1:0]] <= cur_byte;
                  end
               end
            end
            CRC: begin
               if (consume) begin
                  bcnt_q <= bcnt_q + 16'd1;
                  if (bcnt_q[0]) state_q <= END;
               end
            end
            END: begin
               int_q     <= 1'b1;
               release_q <= 1'b1;
               state_q   <= HUNT;
            end
            default: state_q <= HUNT;
         endcase
      end
   end

   assign cam_io.virtual_channel   = vc_q;
   assign cam_io.word_count        = wc_q;
   assign cam_io.image_data        = img_q;
   assign cam_io.image_data_type   = dt_q;
   assign cam_io.image_data_enable = en_q;
   assign cam_io.interrupt         = int_q;
endmodule

// File: tb/tb_camera.sv
// Directed bench for camera: byte packets serialised onto two DDR lanes, pulses logged and compared.
module tb_camera;
   localparam int NL = 2;

   typedef struct packed {
      logic        irq;
      logic        en;
      logic [31:0] data;
      logic [1:0]  vc;
      logic [5:0]  dt;
      logic [15:0] wc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         checks = 0;
   int         errors = 0;
   ev_t        evq[$];
   logic [7:0] pkt[$];

   camera_if #(.NUM_LANES(NL)) cam_io ();
   camera #(.NUM_LANES(NL)) dut (.clock_p(clk), .reset(rst), .cam_io(cam_io));

   always #5 clk = ~clk;

   function automatic logic [31:0] img_word();
      return {cam_io.image_data[3], cam_io.image_data[2], cam_io.image_data[1], cam_io.image_data[0]};
   endfunction

   always @(negedge clk)
      if (cam_io.interrupt === 1'b1 || cam_io.image_data_enable === 1'b1)
         evq.push_back('{cam_io.interrupt, cam_io.image_data_enable, img_word(),
                         cam_io.virtual_channel, cam_io.image_data_type, cam_io.word_count});

   function automatic ev_t ev_at(input int k);
      return (evq.size() > k) ? evq[k] : '0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_vc"},  32'(cam_io.virtual_channel), 32'h0);
      chk({tag, "_wc"},  32'(cam_io.word_count), 32'h0);
      chk({tag, "_dt"},  32'(cam_io.image_data_type), 32'h0);
      chk({tag, "_img"}, img_word(), 32'h0);
      chk({tag, "_en"},  32'(cam_io.image_data_enable), 32'h0);
      chk({tag, "_irq"}, 32'(cam_io.interrupt), 32'h0);
      chk({tag, "_ecc"}, 32'(dut.header_ecc), 32'h0);
   endtask

   // Byte k goes to lane k mod NL, each byte LSB first; lead idle bits shift the alignment.
   task automatic send(input int lead, input int rst_at);
      logic [NL-1:0] bits[$];
      logic [NL-1:0] v;
      int per;
      per = (pkt.size() + NL - 1) / NL;
      for (int t = 0; t < lead; t++) bits.push_back('0);
      for (int bi = 0; bi < per; bi++)
         for (int b = 0; b < 8; b++) begin
            for (int l = 0; l < NL; l++) begin
               int k;
               k = bi * NL + l;
               v[l] = (k < pkt.size()) ? pkt[k][b] : 1'b0;
            end
            bits.push_back(v);
         end
      for (int t = 0; t < 40; t++) bits.push_back('0);
      if (bits.size() % 2 != 0) bits.push_back('0);
      for (int c = 0; c < bits.size() / 2; c++) begin
         @(posedge clk); #1;
         if (c == rst_at) rst = 1'b1;
         cam_io.data_p = bits[2*c];
         @(negedge clk); #1;
         cam_io.data_p = bits[2*c+1];
      end
   endtask

   initial begin
      cam_io.data_p = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1 rst = 1'b0;

      pkt.delete(); evq.delete();
      send(0, -1);
      chk("idle_pulses", 32'(evq.size()), 32'd0);

      pkt = '{8'hB8, 8'hB8, 8'h08, 8'hCE, 8'hFA, 8'h12}; evq.delete();
      send(8, -1);
      chk("short_pulses", 32'(evq.size()), 32'd1);
      chk("short_en",  32'(ev_at(0).en), 32'd0);
      chk("short_vc",  32'(ev_at(0).vc), 32'd0);
      chk("short_dt",  32'(ev_at(0).dt), 32'h08);
      chk("short_wc",  32'(ev_at(0).wc), 32'hFACE);
      chk("short_ecc", 32'(dut.header_ecc), 32'h12);

      pkt = '{8'hB8, 8'hB8, 8'h18, 8'h08, 8'h00, 8'hFE, 8'hAD, 8'hDE, 8'hE1, 8'hFE,
              8'h5E, 8'hEA, 8'h15, 8'h0D, 8'hD0, 8'hF0}; evq.delete();
      send(7, -1);
      chk("long_pulses", 32'(evq.size()), 32'd3);
      chk("long_w0_irq", 32'(ev_at(0).irq), 32'd1);
      chk("long_w0_en",  32'(ev_at(0).en), 32'd1);
      chk("long_w0",     ev_at(0).data, 32'hFEE1DEAD);
      chk("long_w1_en",  32'(ev_at(1).en), 32'd1);
      chk("long_w1",     ev_at(1).data, 32'h0D15EA5E);
      chk("long_end_irq", 32'(ev_at(2).irq), 32'd1);
      chk("long_end_en",  32'(ev_at(2).en), 32'd0);
      chk("long_dt",  32'(cam_io.image_data_type), 32'h18);
      chk("long_wc",  32'(cam_io.word_count), 32'h0008);
      chk("long_ecc", 32'(dut.header_ecc), 32'hFE);

      pkt = '{8'hB8, 8'hB8, 8'h88, 8'h34, 8'h12, 8'hAB}; evq.delete();
      send(3, -1);
      chk("vc2_pulses", 32'(evq.size()), 32'd1);
      chk("vc2_vc", 32'(ev_at(0).vc), 32'd2);
      chk("vc2_dt", 32'(ev_at(0).dt), 32'h08);
      chk("vc2_wc", 32'(ev_at(0).wc), 32'h1234);

      pkt = '{8'hB8, 8'hB8, 8'h12, 8'h05, 8'h00, 8'h33, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'hC1, 8'hC2}; evq.delete();
      send(0, -1);
      chk("wc5_pulses", 32'(evq.size()), 32'd3);
      chk("wc5_w0",     ev_at(0).data, 32'h44332211);
      chk("wc5_w1_en",  32'(ev_at(1).en), 32'd1);
      chk("wc5_w1",     ev_at(1).data, 32'h00000055);
      chk("wc5_end_en", 32'(ev_at(2).en), 32'd0);
      chk("wc5_end_irq", 32'(ev_at(2).irq), 32'd1);

      pkt = '{8'hB8, 8'hB8, 8'h20, 8'h00, 8'h00, 8'h77, 8'hC1, 8'hC2}; evq.delete();
      send(5, -1);
      chk("wc0_pulses", 32'(evq.size()), 32'd1);
      chk("wc0_en", 32'(ev_at(0).en), 32'd0);
      chk("wc0_dt", 32'(ev_at(0).dt), 32'h20);
      chk("wc0_wc", 32'(ev_at(0).wc), 32'h0000);

      pkt = '{8'hB8, 8'h00}; evq.delete();
      send(2, -1);
      chk("onelane_pulses", 32'(evq.size()), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      pkt = '{8'hB8, 8'hB8, 8'h18, 8'h08, 8'h00, 8'hFE, 8'hAD, 8'hDE, 8'hE1, 8'hFE,
              8'h5E, 8'hEA, 8'h15, 8'h0D, 8'hD0, 8'hF0}; evq.delete();
      send(8, 22);
      chk("abort_pulses", 32'(evq.size()), 32'd0);
      chk_zero("abort");
      @(posedge clk); #1 rst = 1'b0;

      pkt = '{8'hB8, 8'hB8, 8'h05, 8'h02, 8'h00, 8'h3C}; evq.delete();
      send(4, -1);
      chk("resume_pulses", 32'(evq.size()), 32'd1);
      chk("resume_en",  32'(ev_at(0).en), 32'd0);
      chk("resume_vc",  32'(ev_at(0).vc), 32'd0);
      chk("resume_dt",  32'(ev_at(0).dt), 32'h05);
      chk("resume_wc",  32'(ev_at(0).wc), 32'h0002);
      chk("resume_ecc", 32'(dut.header_ecc), 32'h3C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/camera.md
CAMERA -- requirements
Module: camera

Interface
REQ-001 Parameter NUM_LANES, default 2, SHALL set the number of CSI-2 data lanes; legal values are 1, 2 and 4.
REQ-002 clock_p  input  1  D-PHY DDR bit clock; the design's only clock; data is sampled on both edges.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_p  input  NUM_LANES  lane data, high-speed bit per clock edge, LSB of each byte first.
REQ-005 virtual_channel  output  2  virtual channel of the current packet (DataID[7:6]).
REQ-006 word_count  output  16  packet word count, {header byte 2, header byte 1}.
REQ-007 image_data  output  4x8 (unpacked [3:0] of bytes)  current payload word; [0] is the earliest byte received.
REQ-008 image_data_type  output  6  data type of the current packet (DataID[5:0]).
REQ-009 image_data_enable  output  1  one-cycle pulse when image_data holds a valid payload word.
REQ-010 interrupt  output  1  one-cycle event pulse; see REQ-017 to REQ-019.

Function
REQ-011 Each lane SHALL deserialize data_p[i] on every rising and falling edge of clock_p into an 8-bit shift register, LSB first.
REQ-012 Each lane SHALL hunt for the sync byte 0xB8 at any bit alignment, then lock byte alignment and emit one byte per 8 bits until the packet ends.
REQ-013 The packet processor SHALL start only when all lanes have locked, and SHALL merge the lane bytes round-robin: byte k comes from lane k mod NUM_LANES.
REQ-014 Header bytes SHALL be taken in this order: DataID, WC LSB, WC MSB, ECC.
REQ-015 The ECC byte SHALL be stored in an internal register named header_ecc; no ECC check or correction is performed.
REQ-016 Outputs SHALL be registered on the rising edge of clock_p, and virtual_channel, word_count and image_data_type SHALL hold until the next header completes.
REQ-017 Short packet (DT 0x00-0x0F): interrupt SHALL pulse for 1 cycle with image_data_enable=0 once the header is complete, and the lanes then return to hunting.
REQ-018 Long packet (DT >= 0x10): after the header, payload bytes SHALL be packed 4 per word; each completed word SHALL give one 1-cycle pulse with interrupt=1 and image_data_enable=1.
REQ-019 After word_count payload bytes and the 2 CRC bytes, interrupt SHALL pulse once with image_data_enable=0 (end of packet), and the lanes then return to hunting.
REQ-020 If word_count mod 4 != 0, the last word SHALL be zero-padded in its upper bytes and still flagged.
REQ-021 word_count = 0 on a long packet SHALL skip the payload, receive the CRC, then give the end-of-packet pulse.
REQ-022 CRC SHALL be consumed but not checked.
REQ-023 Pulses SHALL never overlap a following packet's header; a sync byte arriving during a packet is treated as data.
REQ-024 States: HUNT, HEADER, PAYLOAD, CRC, END, where HUNT goes to HEADER when all lanes are locked, HEADER goes to PAYLOAD if DT >= 0x10 or back to HUNT otherwise, PAYLOAD goes to CRC when the byte count reaches word_count, CRC goes to END after 2 bytes, and END goes to HUNT.

Reset
REQ-025 While reset=1, all lanes SHALL go to HUNT with shift registers cleared, and all outputs SHALL be 0: virtual_channel=0, word_count=0, image_data all 0, image_data_type=0, image_data_enable=0, interrupt=0; header_ecc SHALL also be 0.
REQ-026 Reset asserted mid-packet SHALL abort the packet immediately with no further pulses, and the block SHALL resume at the next sync.

Verification
REQ-027 With 2 lanes, sending B8 B8 08 CE FA 12 SHALL give exactly one interrupt with virtual_channel=0, image_data_type=0x08, word_count=0xFACE, header_ecc=0x12 and image_data_enable=0.
REQ-028 With 2 lanes, sending B8 B8 18 08 00 FE AD DE E1 FE 5E EA 15 0D D0 F0 SHALL give header fields DT 0x18, WC 8, ECC 0xFE, then word pulses {image_data[3..0]} = 0xFEE1DEAD then 0x0D15EA5E, then one end-of-packet interrupt with enable=0.
REQ-029 A short packet with DataID 0x88 SHALL give virtual_channel=2 and image_data_type=0x08.
REQ-030 An idle bus (all zeros), or a sync byte on only one of two lanes, SHALL produce no interrupt.
REQ-031 A long packet with WC=5 SHALL give 2 word pulses, the second holding 1 valid byte in image_data[0] and zeros above, then the end-of-packet pulse.
REQ-032 Reset asserted during the payload of the REQ-028 packet SHALL clear all outputs, and a following short packet SHALL still decode correctly.
